// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic skid pipeline chain.
package pipe_pkg;

    // Stage occupancy encoded as {S.valid, M.valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } stage_state_t;

    // Width needed to hold an occupancy count of 0..2*stages
    function automatic int unsigned count_width(input int unsigned stages);
        return 32'($clog2(2 * stages + 1));
    endfunction

endpackage

// File: rtl/pipe_skid_chain_if.sv
// Valid/ready handshake bundle carrying one payload item.
interface pipe_skid_chain_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// One elastic stage: main entry plus skid entry, all outputs from registers.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i,
    output logic [1:0]       occ
);

    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             in_fire;
    logic             out_fire;

    assign valid_o  = state_q[0];
    assign ready_o  = !state_q[1];
    assign data_o   = m_data_q;
    assign occ      = state_q;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    // State and data registers; async reset clears everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            s_data_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

    // Next state; data only moves on a real transition, flush wins over all
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        if (flush) begin
            state_d  = EMPTY;
            m_data_d = '0;
            s_data_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_data_d = data_i;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_data_d = data_i;
                    end else if (in_fire) begin
                        s_data_d = data_i;
                        state_d  = FULL;
                    end else if (out_fire) begin
                        state_d  = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        m_data_d = s_data_q;
                        state_d  = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_skid_chain.sv
// Chain of elastic skid stages with a registered total occupancy count.
module pipe_skid_chain
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CW     = count_width(STAGES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    pipe_skid_chain_if.slave         up,
    pipe_skid_chain_if.master        dn,
    output logic [CW-1:0]            count
);

    logic             v [STAGES+1];
    logic [WIDTH-1:0] d [STAGES+1];
    logic             r [STAGES+1];
    logic [1:0]       occ [STAGES];
    logic             in_fire;
    logic             out_fire;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    occ_sum;

    assign v[0]      = up.valid;
    assign d[0]      = up.data;
    assign up.ready  = r[0];
    assign dn.valid  = v[STAGES];
    assign dn.data   = d[STAGES];
    assign r[STAGES] = dn.ready;

    assign in_fire  = up.valid & r[0];
    assign out_fire = v[STAGES] & dn.ready;

    // Stage k output feeds stage k+1 input
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_skid_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .valid_i (v[k]),
            .data_i  (d[k]),
            .ready_o (r[k]),
            .valid_o (v[k+1]),
            .data_o  (d[k+1]),
            .ready_i (r[k+1]),
            .occ     (occ[k])
        );
    end

    // Occupancy tracks chain-boundary handshakes only; interior moves net to zero
    always_comb begin
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count + CW'(in_fire) - CW'(out_fire);
        end
    end

    // Registered occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

    // Sum of per-stage valid bits, used only by the consistency check below
    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            occ_sum = occ_sum + CW'(occ[k][0]) + CW'(occ[k][1]);
        end
    end

    // Simulation-only: the incremental count must match the stage valid bits
    a_count_consistent: assert property (@(posedge clk) disable iff (reset) count == occ_sum);

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Directed bench for pipe_skid_chain: vector table plus multi-cycle sequences.
module tb_pipe_skid_chain;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic flush_s;
    logic [2:0] count;
    logic [1:0] count_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_chain_if #(.WIDTH(32)) up_if ();
    pipe_skid_chain_if #(.WIDTH(32)) dn_if ();
    pipe_skid_chain_if #(.WIDTH(8))  up_s ();
    pipe_skid_chain_if #(.WIDTH(8))  dn_s ();

    pipe_skid_chain #(.WIDTH(32), .STAGES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .up    (up_if),
        .dn    (dn_if),
        .count (count)
    );

    pipe_skid_chain #(.WIDTH(8), .STAGES(1)) u_small (
        .clk   (clk),
        .reset (reset),
        .flush (flush_s),
        .up    (up_s),
        .dn    (dn_s),
        .count (count_s)
    );

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic        chk_od;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] send_q [$];
    logic [31:0] got_q  [$];
    int          send_idx;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_seq();
        send_q.delete();
        got_q.delete();
        send_idx = 0;
    endtask

    // One cycle: offer the next pending item, sample handshakes at negedge
    task automatic xfer_cycle(input logic ordy);
        up_if.valid = (send_idx < send_q.size());
        up_if.data  = (send_idx < send_q.size()) ? send_q[send_idx] : 32'h0;
        dn_if.ready = ordy;
        @(negedge clk);
        if (up_if.valid && up_if.ready) send_idx++;
        if (dn_if.valid && dn_if.ready) got_q.push_back(dn_if.data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        flush_s     = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        up_s.valid  = 1'b0;
        up_s.data   = '0;
        dn_s.ready  = 1'b0;

        // Streaming 1..8 with out_ready high, then two idle drain cycles
        tbl[0] = '{1'b1, 32'h1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 3'd1};
        tbl[1] = '{1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 3'd2};
        tbl[2] = '{1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h2, 1'b1, 3'd2};
        tbl[3] = '{1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h3, 1'b1, 3'd2};
        tbl[4] = '{1'b1, 32'h5, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 3'd2};
        tbl[5] = '{1'b1, 32'h6, 1'b1, 1'b1, 1'b1, 32'h5, 1'b1, 3'd2};
        tbl[6] = '{1'b1, 32'h7, 1'b1, 1'b1, 1'b1, 32'h6, 1'b1, 3'd2};
        tbl[7] = '{1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 32'h7, 1'b1, 3'd2};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 3'd1};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 3'd0};

        // Reset state, while held and after release
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_out_valid", 32'(dn_if.valid), 32'h0);
        check("rst_held_out_data",  dn_if.data,       32'h0);
        check("rst_held_in_ready",  32'(up_if.ready), 32'h1);
        check("rst_held_count",     32'(count),       32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rel_out_valid", 32'(dn_if.valid), 32'h0);
        check("rst_rel_in_ready",  32'(up_if.ready), 32'h1);
        check("rst_rel_count",     32'(count),       32'h0);

        // Table-driven streaming
        for (int i = 0; i < 10; i++) begin
            up_if.valid = tbl[i].iv;
            up_if.data  = tbl[i].id;
            dn_if.ready = tbl[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_in_ready", i),  32'(up_if.ready), 32'(tbl[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), 32'(dn_if.valid), 32'(tbl[i].e_ov));
            if (tbl[i].chk_od) check($sformatf("vec%0d_out_data", i), dn_if.data, tbl[i].e_od);
            check($sformatf("vec%0d_count", i),     32'(count),       32'(tbl[i].e_cnt));
        end
        up_if.valid = 1'b0;

        // Backpressure: only four items fit, then ordered drain
        start_seq();
        for (int i = 0; i < 6; i++) send_q.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) xfer_cycle(1'b0);
        check("bp_count_full",   32'(count),       32'h4);
        check("bp_in_ready_low", 32'(up_if.ready), 32'h0);
        check("bp_head_data",    dn_if.data,       32'hA0);
        xfer_cycle(1'b0);
        check("bp_accepted", 32'(send_idx), 32'h4);
        for (int c = 0; c < 40 && got_q.size() < 6; c++) xfer_cycle(1'b1);
        check("bp_drain_n", 32'(got_q.size()), 32'h6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check($sformatf("bp_drain%0d", i), got_q[i], 32'hA0 + 32'(i));

        // Alternating out_ready with continuous input
        start_seq();
        for (int i = 0; i < 16; i++) send_q.push_back(32'h10 + 32'(i));
        for (int c = 0; c < 100 && got_q.size() < 16; c++) xfer_cycle(c % 2 == 0);
        check("alt_n", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            check($sformatf("alt%0d", i), got_q[i], 32'h10 + 32'(i));
        check("alt_count_end", 32'(count), 32'h0);

        // Flush with three items held and 0x55 offered in the flush cycle
        start_seq();
        send_q.push_back(32'h31);
        send_q.push_back(32'h32);
        send_q.push_back(32'h33);
        for (int i = 0; i < 3; i++) xfer_cycle(1'b0);
        check("fl_count_pre", 32'(count), 32'h3);
        up_if.valid = 1'b1;
        up_if.data  = 32'h55;
        dn_if.ready = 1'b0;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        up_if.valid = 1'b0;
        check("fl_count",     32'(count),       32'h0);
        check("fl_out_valid", 32'(dn_if.valid), 32'h0);
        check("fl_in_ready",  32'(up_if.ready), 32'h1);
        check("fl_out_data",  dn_if.data,       32'h0);
        start_seq();
        for (int i = 0; i < 6; i++) xfer_cycle(1'b1);
        check("fl_no_leak", 32'(got_q.size()), 32'h0);

        // Single-stage, 8-bit chain: fill, stall, one output frees a slot
        up_s.valid = 1'b1;
        up_s.data  = 8'h11;
        dn_s.ready = 1'b0;
        @(posedge clk);
        #1;
        up_s.data = 8'h22;
        @(posedge clk);
        #1;
        up_s.valid = 1'b0;
        check("s1_count_full", 32'(count_s),     32'h2);
        check("s1_in_ready",   32'(up_s.ready),  32'h0);
        check("s1_head",       32'(dn_s.data),   32'h11);
        dn_s.ready = 1'b1;
        @(posedge clk);
        #1;
        dn_s.ready = 1'b0;
        check("s1_in_ready_back", 32'(up_s.ready), 32'h1);
        check("s1_count_one",     32'(count_s),    32'h1);
        check("s1_head_next",     32'(dn_s.data),  32'h22);

        // Async reset between edges while data is in flight
        start_seq();
        for (int i = 0; i < 4; i++) send_q.push_back(32'h61 + 32'(i));
        for (int i = 0; i < 3; i++) xfer_cycle(1'b1);
        check("ar_pre_out_valid", 32'(dn_if.valid), 32'h1);
        up_if.valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_out_valid", 32'(dn_if.valid), 32'h0);
        check("ar_out_data",  dn_if.data,       32'h0);
        check("ar_count",     32'(count),       32'h0);
        check("ar_in_ready",  32'(up_if.ready), 32'h1);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ar_post_out_valid", 32'(dn_if.valid), 32'h0);
        check("ar_post_count",     32'(count),       32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
